// File: rtl/led_pattern_pkg.sv
// Shared mode encoding for the LED pattern generator.
package led_pattern_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

endpackage

// File: rtl/led_prescaler.sv
// Pattern-step prescaler: counts enabled cycles and flags the last one of each period.
module led_prescaler #(
    parameter int PRESCALE_DIV = 50_000_000
) (
    input  logic clkin,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(PRESCALE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_LAST);

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, bouncing scan, PWM breathe or off, stepped by a prescaler tick.
//   mode         | meaning
//   MODE_BINARY  | leds count up once per tick
//   MODE_SCAN    | one-hot bounces between bit 0 and bit NUM_LEDS-1
//   MODE_BREATHE | all leds = pwm_q < duty_q, duty ramps up/down per tick
//   MODE_OFF     | leds held at zero
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS     = 12,
    parameter int PRESCALE_DIV = 50_000_000,
    parameter int PWM_W        = 8
) (
    input  logic                clkin,
    input  logic                resetn,
    input  logic                enable,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic                mode_load,
    output logic [NUM_LEDS-1:0] leds,
    output logic [MODE_W-1:0]   mode_o,
    output logic                tick_o
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic                tick;
    mode_t               mode_q, mode_d;
    mode_t               pend_mode;
    logic                pend_valid;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    logic [PWM_W-1:0]    duty_q, duty_d;
    logic                dir_up_q, dir_up_d;
    logic [NUM_LEDS-1:0] leds_d;

    led_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clkin (clkin),
        .resetn(resetn),
        .enable(enable),
        .tick  (tick)
    );

    assign tick_o = tick;
    assign mode_o = mode_q;

    always_comb begin
        mode_d   = mode_q;
        pwm_d    = pwm_q;
        duty_d   = duty_q;
        dir_up_d = dir_up_q;
        leds_d   = leds;
        if (enable) begin
            pwm_d = pwm_q + PWM_W'(1);
            if (tick && pend_valid) begin
                mode_d   = pend_mode;
                duty_d   = '0;
                dir_up_d = 1'b1;
                leds_d   = (pend_mode == MODE_SCAN) ? NUM_LEDS'(1) : '0;
            end else if (tick) begin
                case (mode_q)
                    MODE_BINARY: leds_d = leds + NUM_LEDS'(1);
                    MODE_SCAN: begin
                        // Reverse at an end without repeating the end position.
                        if (dir_up_q) begin
                            if (leds[NUM_LEDS-1]) begin
                                leds_d   = leds >> 1;
                                dir_up_d = 1'b0;
                            end else begin
                                leds_d = leds << 1;
                            end
                        end else begin
                            if (leds[0]) begin
                                leds_d   = leds << 1;
                                dir_up_d = 1'b1;
                            end else begin
                                leds_d = leds >> 1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        if (dir_up_q) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_d   = duty_q - PWM_W'(1);
                                dir_up_d = 1'b0;
                            end else begin
                                duty_d = duty_q + PWM_W'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_d   = PWM_W'(1);
                                dir_up_d = 1'b1;
                            end else begin
                                duty_d = duty_q - PWM_W'(1);
                            end
                        end
                    end
                    default: leds_d = '0;
                endcase
            end
            // Registered leds track the registered pwm/duty pair, so duty 0 is always dark.
            if (mode_d == MODE_BREATHE) begin
                leds_d = {NUM_LEDS{pwm_d < duty_d}};
            end
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= MODE_BINARY;
            pwm_q      <= '0;
            duty_q     <= '0;
            dir_up_q   <= 1'b1;
            leds       <= '0;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_BINARY;
        end else begin
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            duty_q   <= duty_d;
            dir_up_q <= dir_up_d;
            leds     <= leds_d;
            // A strobe in a tick cycle survives the tick and is applied at the next one.
            if (mode_load) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_t'(mode_i);
            end else if (tick) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
